// File: rtl/instr_fetch_buffer_pkg.sv
// Shared types and constants for the instruction fetch buffer.
//   fetch_entry_t  - one queued fetch result {pc, instr, misaligned}
//   fetch_state_e  - fetch request state machine states
//   NOP_INSTR      - canonical no-op encoding, available to decode
//   is_aligned()   - word-alignment test on the low address bits
package fetch_pkg;

    localparam int FETCH_XLEN = 32;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [FETCH_XLEN-1:0] pc;
        logic [FETCH_XLEN-1:0] instr;
        logic                  misaligned;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DRAIN
    } fetch_state_e;

    // A fetch address is usable only when it points at a whole word.
    function automatic logic is_aligned(input logic [1:0] low_bits);
        return (low_bits == 2'b00);
    endfunction

endpackage

// File: rtl/instr_fetch_buffer_sync_fifo.sv
// Small synchronous FIFO holding fetch results.
//   clk, rst_n  - clock and asynchronous active-low reset
//   push        - write push_data at the tail (ignored when full unless popping)
//   pop         - drop the head entry (ignored when empty)
//   clear       - empty the FIFO, overriding push and pop
//   count       - number of stored entries, 0..DEPTH
//   head        - entry at the head, read straight from storage
module sync_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = logic
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  T                           push_data,
    input  logic                       pop,
    input  logic                       clear,
    output logic [$clog2(DEPTH):0]     count,
    output T                           head
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;
    T              mem [DEPTH];

    // A pop needs something to remove; a push needs room, which a
    // simultaneous pop provides even when the FIFO is full.
    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
    assign head    = mem[rd_ptr];

    // Storage, pointers and occupancy. Pointers wrap naturally because
    // DEPTH is a power of two. Clear only rewinds the bookkeeping; the
    // stale storage is unreachable until overwritten.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch_buffer.sv
// Fetch-stage buffer between the PC register and decode.
//   clk, rst_n                 - clock and asynchronous active-low reset
//   pc_valid/pc_in/pc_ready    - PC handshake from the PC register
//   flush                      - redirect: drop queued and in-flight fetches
//   imem_req/imem_addr         - word read request to instruction memory
//   imem_gnt                   - memory accepted the request
//   imem_rvalid/imem_rdata     - read response
//   if_valid/if_ready          - head handshake to decode
//   if_pc/if_instr             - head entry contents
//   if_misaligned              - head PC was not word aligned (if_instr = 0)
module instr_fetch_buffer
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = FETCH_XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pc_valid,
    input  logic [XLEN-1:0] pc_in,
    output logic            pc_ready,
    input  logic            flush,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_instr,
    output logic            if_misaligned
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    fetch_state_e  state;
    logic          drop_resp;
    logic [CW-1:0] fill_count;
    logic [CW-1:0] reserved_count;
    logic          inflight;
    logic          accept;
    logic          aligned;
    logic          push;
    logic          pop;
    fetch_entry_t  push_entry;
    fetch_entry_t  head;

    // Occupancy counts the slot held back for an outstanding fetch so a
    // returning response can always be stored. A drained response never
    // lands, so DRAIN does not reserve a slot.
    assign inflight       = (state == REQ) || (state == WAIT);
    assign reserved_count = fill_count + {{(CW-1){1'b0}}, inflight};
    assign pc_ready       = rst_n && (state == IDLE) && !flush && (reserved_count < DEPTH_C);
    assign accept         = pc_valid && pc_ready;
    assign aligned        = is_aligned(pc_in[1:0]);
    assign pop            = if_valid && if_ready && !flush;

    assign if_valid       = (fill_count != '0);
    assign if_pc          = head.pc;
    assign if_instr       = head.instr;
    assign if_misaligned  = head.misaligned;

    // Choose what, if anything, enters the FIFO this cycle. Misaligned PCs
    // bypass memory entirely; real responses are kept only when neither the
    // current cycle nor an earlier one (drop_resp) asked to discard them.
    always_comb begin
        push       = 1'b0;
        push_entry = '0;
        if (accept && !aligned) begin
            push                  = 1'b1;
            push_entry.pc         = pc_in;
            push_entry.instr      = '0;
            push_entry.misaligned = 1'b1;
        end else if (!flush && imem_rvalid &&
                     ((state == WAIT) || ((state == REQ) && imem_gnt && !drop_resp))) begin
            push                  = 1'b1;
            push_entry.pc         = imem_addr;
            push_entry.instr      = imem_rdata;
            push_entry.misaligned = 1'b0;
        end
    end

    // Request state machine. imem_addr doubles as the stored PC of the
    // outstanding fetch. A request, once raised, is never withdrawn; a flush
    // seen while still waiting for the grant is remembered in drop_resp so
    // the eventual response is drained instead of queued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            imem_req  <= 1'b0;
            imem_addr <= '0;
            drop_resp <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept && aligned) begin
                        state     <= REQ;
                        imem_req  <= 1'b1;
                        imem_addr <= pc_in;
                        drop_resp <= 1'b0;
                    end
                end
                REQ: begin
                    if (imem_gnt) begin
                        imem_req  <= 1'b0;
                        drop_resp <= 1'b0;
                        if (imem_rvalid) begin
                            state <= IDLE;
                        end else if (flush || drop_resp) begin
                            state <= DRAIN;
                        end else begin
                            state <= WAIT;
                        end
                    end else if (flush) begin
                        drop_resp <= 1'b1;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        state <= IDLE;
                    end else if (flush) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (imem_rvalid) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Result queue towards decode; flush empties it ahead of any push/pop.
    sync_fifo #(
        .DEPTH (DEPTH),
        .T     (fetch_entry_t)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .clear     (flush),
        .count     (fill_count),
        .head      (head)
    );

    // A response with no request outstanding means the memory and this
    // block disagree about the transaction in flight.
    rvalid_while_idle: assert property (
        @(posedge clk) disable iff (!rst_n) !(imem_rvalid && (state == IDLE))
    );

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Directed bench for instr_fetch_buffer: a table of per-cycle vectors for
// the basic fetch paths, plus hand-written sequences for flush and reset.
module tb_instr_fetch_buffer;

    logic        clk;
    logic        rst_n;
    logic        pc_valid;
    logic [31:0] pc_in;
    logic        pc_ready;
    logic        flush;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_misaligned;

    int tests_run;
    int tests_failed;

    typedef struct {
        logic        pv;
        logic [31:0] pc;
        logic        fl;
        logic        gnt;
        logic        rv;
        logic [31:0] rd;
        logic        rdy;
        logic        e_pcr;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_ifv;
        logic [31:0] e_ifpc;
        logic [31:0] e_instr;
        logic        e_mis;
    } vec_t;

    vec_t tbl[$];

    instr_fetch_buffer #(
        .DEPTH (4),
        .XLEN  (32)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pc_valid      (pc_valid),
        .pc_in         (pc_in),
        .pc_ready      (pc_ready),
        .flush         (flush),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_gnt      (imem_gnt),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .if_valid      (if_valid),
        .if_ready      (if_ready),
        .if_pc         (if_pc),
        .if_instr      (if_instr),
        .if_misaligned (if_misaligned)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net so the run always ends even if the sequencing breaks.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mkv(
        input logic pv, input logic [31:0] pc, input logic fl,
        input logic gnt, input logic rv, input logic [31:0] rd, input logic rdy,
        input logic e_pcr, input logic e_req, input logic [31:0] e_addr,
        input logic e_ifv, input logic [31:0] e_ifpc, input logic [31:0] e_instr,
        input logic e_mis);
        vec_t v;
        v.pv = pv; v.pc = pc; v.fl = fl; v.gnt = gnt; v.rv = rv; v.rd = rd; v.rdy = rdy;
        v.e_pcr = e_pcr; v.e_req = e_req; v.e_addr = e_addr; v.e_ifv = e_ifv;
        v.e_ifpc = e_ifpc; v.e_instr = e_instr; v.e_mis = e_mis;
        return v;
    endfunction

    // Drive one cycle's inputs just after the falling edge.
    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        pc_valid    = v.pv;
        pc_in       = v.pc;
        flush       = v.fl;
        imem_gnt    = v.gnt;
        imem_rvalid = v.rv;
        imem_rdata  = v.rd;
        if_ready    = v.rdy;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Apply a vector and compare outputs mid-cycle, before the next rising edge.
    task automatic runVector(input vec_t v, input string tag);
        applyStimulus(v);
        #1;
        checkOutput({tag, ".pc_ready"}, {31'd0, pc_ready}, {31'd0, v.e_pcr});
        checkOutput({tag, ".imem_req"}, {31'd0, imem_req}, {31'd0, v.e_req});
        checkOutput({tag, ".imem_addr"}, imem_addr, v.e_addr);
        checkOutput({tag, ".if_valid"}, {31'd0, if_valid}, {31'd0, v.e_ifv});
        if (v.e_ifv) begin
            checkOutput({tag, ".if_pc"}, if_pc, v.e_ifpc);
            checkOutput({tag, ".if_instr"}, if_instr, v.e_instr);
            checkOutput({tag, ".if_misaligned"}, {31'd0, if_misaligned}, {31'd0, v.e_mis});
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, ".pc_ready"}, {31'd0, pc_ready}, 32'd0);
        checkOutput({tag, ".imem_req"}, {31'd0, imem_req}, 32'd0);
        checkOutput({tag, ".imem_addr"}, imem_addr, 32'd0);
        checkOutput({tag, ".if_valid"}, {31'd0, if_valid}, 32'd0);
        checkOutput({tag, ".if_pc"}, if_pc, 32'd0);
        checkOutput({tag, ".if_instr"}, if_instr, 32'd0);
        checkOutput({tag, ".if_misaligned"}, {31'd0, if_misaligned}, 32'd0);
    endtask

    task automatic driveIdle();
        pc_valid    = 1'b0;
        pc_in       = 32'd0;
        flush       = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'd0;
        if_ready    = 1'b0;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        driveIdle();

        repeat (2) @(negedge clk);
        #1;
        checkResetOutputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Zero-wait fetch, misaligned PC, then back-pressure to a full FIFO.
        //            pv  pc        fl gnt rv rd            rdy   pcr req addr      ifv ifpc      instr         mis
        tbl.push_back(mkv(1, 32'h0,  0, 0, 0, 32'h0,        0,    1, 0, 32'h0,    0, 32'h0, 32'h0,        0));
        tbl.push_back(mkv(0, 32'h0,  0, 1, 1, 32'h00500093, 0,    0, 1, 32'h0,    0, 32'h0, 32'h0,        0));
        tbl.push_back(mkv(0, 32'h0,  0, 0, 0, 32'h0,        1,    1, 0, 32'h0,    1, 32'h0, 32'h00500093, 0));
        tbl.push_back(mkv(1, 32'h6,  0, 0, 0, 32'h0,        0,    1, 0, 32'h0,    0, 32'h0, 32'h0,        0));
        tbl.push_back(mkv(0, 32'h0,  0, 0, 0, 32'h0,        1,    1, 0, 32'h0,    1, 32'h6, 32'h0,        1));
        tbl.push_back(mkv(0, 32'h0,  0, 0, 0, 32'h0,        0,    1, 0, 32'h0,    0, 32'h0, 32'h0,        0));
        tbl.push_back(mkv(1, 32'h0,  0, 0, 0, 32'h0,        0,    1, 0, 32'h0,    0, 32'h0, 32'h0,        0));
        tbl.push_back(mkv(0, 32'h0,  0, 1, 1, 32'hA0A0A0A0, 0,    0, 1, 32'h0,    0, 32'h0, 32'h0,        0));
        tbl.push_back(mkv(1, 32'h4,  0, 0, 0, 32'h0,        0,    1, 0, 32'h0,    1, 32'h0, 32'hA0A0A0A0, 0));
        tbl.push_back(mkv(0, 32'h0,  0, 1, 1, 32'hA1A1A1A1, 0,    0, 1, 32'h4,    1, 32'h0, 32'hA0A0A0A0, 0));
        tbl.push_back(mkv(1, 32'h8,  0, 0, 0, 32'h0,        0,    1, 0, 32'h4,    1, 32'h0, 32'hA0A0A0A0, 0));
        tbl.push_back(mkv(0, 32'h0,  0, 1, 1, 32'hA2A2A2A2, 0,    0, 1, 32'h8,    1, 32'h0, 32'hA0A0A0A0, 0));
        tbl.push_back(mkv(1, 32'hC,  0, 0, 0, 32'h0,        0,    1, 0, 32'h8,    1, 32'h0, 32'hA0A0A0A0, 0));
        tbl.push_back(mkv(0, 32'h0,  0, 1, 1, 32'hA3A3A3A3, 0,    0, 1, 32'hC,    1, 32'h0, 32'hA0A0A0A0, 0));
        tbl.push_back(mkv(1, 32'h10, 0, 0, 0, 32'h0,        0,    0, 0, 32'hC,    1, 32'h0, 32'hA0A0A0A0, 0));
        tbl.push_back(mkv(1, 32'h10, 0, 0, 0, 32'h0,        1,    0, 0, 32'hC,    1, 32'h0, 32'hA0A0A0A0, 0));
        tbl.push_back(mkv(0, 32'h0,  0, 0, 0, 32'h0,        0,    1, 0, 32'hC,    1, 32'h4, 32'hA1A1A1A1, 0));
        tbl.push_back(mkv(0, 32'h0,  0, 0, 0, 32'h0,        1,    1, 0, 32'hC,    1, 32'h4, 32'hA1A1A1A1, 0));
        tbl.push_back(mkv(0, 32'h0,  0, 0, 0, 32'h0,        1,    1, 0, 32'hC,    1, 32'h8, 32'hA2A2A2A2, 0));
        tbl.push_back(mkv(0, 32'h0,  0, 0, 0, 32'h0,        1,    1, 0, 32'hC,    1, 32'hC, 32'hA3A3A3A3, 0));
        tbl.push_back(mkv(0, 32'h0,  0, 0, 0, 32'h0,        0,    1, 0, 32'hC,    0, 32'h0, 32'h0,        0));

        foreach (tbl[i]) begin
            runVector(tbl[i], $sformatf("vec%0d", i));
        end

        // Flush while waiting for data; late response is dropped, 0x40 fetched after.
        runVector(mkv(1, 32'h10, 0, 0, 0, 32'h0,        0, 1, 0, 32'hC,  0, 32'h0,  32'h0,        0), "fw_a");
        runVector(mkv(0, 32'h0,  0, 1, 0, 32'h0,        0, 0, 1, 32'h10, 0, 32'h0,  32'h0,        0), "fw_b");
        runVector(mkv(0, 32'h0,  1, 0, 0, 32'h0,        0, 0, 0, 32'h10, 0, 32'h0,  32'h0,        0), "fw_c");
        runVector(mkv(0, 32'h0,  0, 0, 0, 32'h0,        0, 0, 0, 32'h10, 0, 32'h0,  32'h0,        0), "fw_d");
        runVector(mkv(0, 32'h0,  0, 0, 1, 32'hDEADBEEF, 1, 0, 0, 32'h10, 0, 32'h0,  32'h0,        0), "fw_e");
        runVector(mkv(0, 32'h0,  0, 0, 0, 32'h0,        1, 1, 0, 32'h10, 0, 32'h0,  32'h0,        0), "fw_f");
        runVector(mkv(1, 32'h40, 0, 0, 0, 32'h0,        0, 1, 0, 32'h10, 0, 32'h0,  32'h0,        0), "fw_g");
        runVector(mkv(0, 32'h0,  0, 1, 1, 32'h00A00113, 0, 0, 1, 32'h40, 0, 32'h0,  32'h0,        0), "fw_h");
        runVector(mkv(0, 32'h0,  0, 0, 0, 32'h0,        1, 1, 0, 32'h40, 1, 32'h40, 32'h00A00113, 0), "fw_i");
        runVector(mkv(0, 32'h0,  0, 0, 0, 32'h0,        0, 1, 0, 32'h40, 0, 32'h0,  32'h0,        0), "fw_j");

        // Flush before the grant: request held three more cycles, response drained.
        runVector(mkv(1, 32'h20, 0, 0, 0, 32'h0,        0, 1, 0, 32'h40, 0, 32'h0, 32'h0, 0), "fr_a");
        runVector(mkv(0, 32'h0,  1, 0, 0, 32'h0,        0, 0, 1, 32'h20, 0, 32'h0, 32'h0, 0), "fr_b");
        runVector(mkv(0, 32'h0,  0, 0, 0, 32'h0,        0, 0, 1, 32'h20, 0, 32'h0, 32'h0, 0), "fr_c");
        runVector(mkv(0, 32'h0,  0, 0, 0, 32'h0,        0, 0, 1, 32'h20, 0, 32'h0, 32'h0, 0), "fr_d");
        runVector(mkv(0, 32'h0,  0, 1, 0, 32'h0,        0, 0, 1, 32'h20, 0, 32'h0, 32'h0, 0), "fr_e");
        runVector(mkv(0, 32'h0,  0, 0, 1, 32'hBADC0DE0, 1, 0, 0, 32'h20, 0, 32'h0, 32'h0, 0), "fr_f");
        runVector(mkv(0, 32'h0,  0, 0, 0, 32'h0,        1, 1, 0, 32'h20, 0, 32'h0, 32'h0, 0), "fr_g");

        // Flush with a queued entry: pop and new PC in the flush cycle are ignored.
        runVector(mkv(1, 32'h5, 0, 0, 0, 32'h0, 0, 1, 0, 32'h20, 0, 32'h0, 32'h0, 0), "fc_a");
        runVector(mkv(1, 32'h8, 1, 0, 0, 32'h0, 1, 0, 0, 32'h20, 1, 32'h5, 32'h0, 1), "fc_b");
        runVector(mkv(0, 32'h0, 0, 0, 0, 32'h0, 0, 1, 0, 32'h20, 0, 32'h0, 32'h0, 0), "fc_c");

        // Asynchronous reset while a fetch waits for data and the FIFO holds an entry.
        runVector(mkv(1, 32'h2,  0, 0, 0, 32'h0, 0, 1, 0, 32'h20, 0, 32'h0, 32'h0, 0), "rw_a");
        runVector(mkv(1, 32'h30, 0, 0, 0, 32'h0, 0, 1, 0, 32'h20, 1, 32'h2, 32'h0, 1), "rw_b");
        runVector(mkv(0, 32'h0,  0, 1, 0, 32'h0, 0, 0, 1, 32'h30, 1, 32'h2, 32'h0, 1), "rw_c");
        @(negedge clk);
        driveIdle();
        #1;
        checkOutput("rw_pre.if_valid", {31'd0, if_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        checkResetOutputs("rw_reset");
        @(negedge clk);
        rst_n = 1'b1;
        runVector(mkv(1, 32'h50, 0, 0, 0, 32'h0,        0, 1, 0, 32'h0,  0, 32'h0,  32'h0,        0), "rw_d");
        runVector(mkv(0, 32'h0,  0, 1, 1, 32'h12345678, 0, 0, 1, 32'h50, 0, 32'h0,  32'h0,        0), "rw_e");
        runVector(mkv(0, 32'h0,  0, 0, 0, 32'h0,        1, 1, 0, 32'h50, 1, 32'h50, 32'h12345678, 0), "rw_f");
        runVector(mkv(0, 32'h0,  0, 0, 0, 32'h0,        0, 1, 0, 32'h50, 0, 32'h0,  32'h0,        0), "rw_g");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
